// File: rtl/pow8_arb_pkg.sv
// Shared constants and helpers for the pow8 engine sharing arbiter.
package pow8_arb_pkg;

  localparam int unsigned DATA_W       = 32;
  localparam int unsigned RES_W        = 64;
  localparam int unsigned ENGINE_DEPTH = 3;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned span;
    res  = 0;
    span = 1;
    while (span < value) begin
      span = span << 1;
      res++;
    end
    return res;
  endfunction

endpackage

// File: rtl/pow8_rr_arbiter.sv
// Round-robin arbiter: first requester at or above ptr_i (with wrap) wins.
module pow8_rr_arbiter
  import pow8_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IdxW = (clog2(N_REQ) > 0) ? clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IdxW-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IdxW-1:0]  idx_o,
  output logic             valid_o
);

  int unsigned cand;
  logic [IdxW-1:0] cand_idx;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand     = (32'(ptr_i) + k) % N_REQ;
      cand_idx = IdxW'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o = 1'b1;
        idx_o   = cand_idx;
      end
    end
    if (valid_o) begin
      gnt_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/pow8_share_arb.sv
// Shares one in-order pow8 engine among N_REQ requesters; an owner-tag FIFO
// steers each engine result back to the requester that issued the operand.
module pow8_share_arb
  import pow8_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned TAG_DEPTH = 4,
  localparam int unsigned TAG_W    = clog2(N_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_REQ-1:0]          req_valid_i,
  output logic [N_REQ-1:0]          req_ready_o,
  input  logic [N_REQ*DATA_W-1:0]   req_data_i,
  output logic [N_REQ-1:0]          rsp_valid_o,
  input  logic [N_REQ-1:0]          rsp_ready_i,
  output logic [RES_W-1:0]          rsp_data_o,
  output logic                      e_s_valid_o,
  input  logic                      e_s_ready_i,
  output logic [DATA_W-1:0]         e_s_data_o,
  input  logic                      e_m_valid_i,
  output logic                      e_m_ready_o,
  input  logic [RES_W-1:0]          e_m_data_i,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int unsigned PtrW = clog2(TAG_DEPTH);
  localparam int unsigned CntW = clog2(TAG_DEPTH + 1);

  logic [TAG_W-1:0] tag_mem_q [TAG_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             err_q, err_d;

  logic             full, empty, push, pop;
  logic [N_REQ-1:0] gnt;
  logic [TAG_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic [TAG_W-1:0] head;

  pow8_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req_i   (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx),
    .valid_o (gnt_valid)
  );

  assign full  = (count_q == CntW'(TAG_DEPTH));
  assign empty = (count_q == '0);

  // Issue side: valid never looks at e_s_ready_i.
  assign e_s_valid_o = gnt_valid & ~full;
  assign req_ready_o = gnt & {N_REQ{e_s_ready_i & ~full}};
  assign push        = e_s_valid_o & e_s_ready_i;

  always_comb begin
    e_s_data_o = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt_idx == TAG_W'(i)) begin
        e_s_data_o = req_data_i[DATA_W*i +: DATA_W];
      end
    end
  end

  // Return side: the FIFO head owns whatever the engine presents.
  assign head        = tag_mem_q[rd_ptr_q];
  assign e_m_ready_o = rsp_ready_i[head] & ~empty;
  assign rsp_data_o  = e_m_data_i;
  assign pop         = e_m_valid_i & e_m_ready_o;

  always_comb begin
    rsp_valid_o = '0;
    if (e_m_valid_i && !empty) begin
      rsp_valid_o[head] = 1'b1;
    end
  end

  assign busy_o = ~empty;
  assign err_o  = err_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rr_ptr_d = rr_ptr_q;
    err_d    = err_q | (e_m_valid_i & empty);
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(TAG_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      rr_ptr_d = (gnt_idx == TAG_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(TAG_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  // Tag storage is only read when count_q says it holds a live entry.
  always_ff @(posedge clk_i) begin
    if (push) begin
      tag_mem_q[wr_ptr_q] <= gnt_idx;
    end
  end

endmodule
